// File: rtl/div_share_sequencer.sv
// rtl/div_share_sequencer.sv - round-robin shared iterative restoring divider
//
// Purpose:
//   Two requesters share one restoring divider that resolves one quotient
//   bit per cycle with a single subtract/restore row. Requests are
//   arbitrated round-robin; each result comes back on one valid/ready
//   channel tagged with the id of the requester that issued it.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   req0_valid/ready/dividend/divisor   requester 0 operation channel
//   req1_valid/ready/dividend/divisor   requester 1 operation channel
//   out_valid/ready                 result handshake
//   out_quotient, out_remainder     Q and R (Q = all ones, R = A on B == 0)
//   out_id                          requester that issued the result
//   out_div0                        divisor was zero
//   busy                            an operation is in flight or waiting
//
// Requires WIDTH >= 2.

module div_share_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_dividend,
  input  logic [WIDTH-1:0] req0_divisor,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_dividend,
  input  logic [WIDTH-1:0] req1_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_id,
  output logic             out_div0,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             last_grant;
  logic             id_r;
  logic             div0_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] p_r;
  logic [WIDTH-1:0] q_r;
  logic [CW-1:0]    cnt;

  logic             grant_any;
  logic             grant_id;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  logic             a_bit;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] restore;

  // Arbitration: a lone requester wins outright; on a tie the requester
  // that did not win last time goes first.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Readys are suppressed while reset is asserted so nothing is accepted
  // on the same edge that clears the block.
  assign accept = rst_n && (state == IDLE) && grant_any;
  assign sel_a  = grant_id ? req1_dividend : req0_dividend;
  assign sel_b  = grant_id ? req1_divisor  : req0_divisor;

  // One restoring row: shift the next dividend bit into the partial
  // remainder and try to subtract B. A borrow means keep the shifted value.
  // The restored value always fits WIDTH bits because it is below B.
  assign a_bit   = a_r[cnt];
  assign diff    = {p_r, a_bit} - {1'b0, b_r};
  assign restore = {p_r[WIDTH-2:0], a_bit};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = accept && !grant_id;
        req1_ready = accept &&  grant_id;
        if (accept) begin
          state_nxt = (sel_b == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      id_r       <= 1'b0;
      div0_r     <= 1'b0;
      a_r        <= '0;
      b_r        <= '0;
      p_r        <= '0;
      q_r        <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r        <= sel_a;
            b_r        <= sel_b;
            id_r       <= grant_id;
            last_grant <= grant_id;
            cnt        <= CW'(WIDTH - 1);
            if (sel_b == '0) begin
              // Same answer the array divider gives for a zero divisor.
              q_r    <= '1;
              p_r    <= sel_a;
              div0_r <= 1'b1;
            end else begin
              q_r    <= '0;
              p_r    <= '0;
              div0_r <= 1'b0;
            end
          end
        end
        RUN: begin
          q_r[cnt] <= ~diff[WIDTH];
          p_r      <= diff[WIDTH] ? restore : diff[WIDTH-1:0];
          cnt      <= cnt - 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign out_quotient  = q_r;
  assign out_remainder = p_r;
  assign out_id        = id_r;
  assign out_div0      = div0_r;

endmodule

// File: tb/tb_div_share_sequencer.sv
// tb/tb_div_share_sequencer.sv - directed and exhaustive bench for div_share_sequencer

module tb_div_share_sequencer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_dividend;
  logic [W-1:0] req0_divisor;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_dividend;
  logic [W-1:0] req1_divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_quotient;
  logic [W-1:0] out_remainder;
  logic         out_id;
  logic         out_div0;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_share_sequencer #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_dividend (req0_dividend),
    .req0_divisor  (req0_divisor),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_dividend (req1_dividend),
    .req1_divisor  (req1_divisor),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .out_id        (out_id),
    .out_div0      (out_div0),
    .busy          (busy)
  );

  // Called at the negedge after the accept edge; n counts clock edges from
  // the accept edge (inclusive) until out_valid is seen. Bounded at 50.
  task automatic wait_out(output int n);
    n = 1;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_dividend = 4'd5; req0_divisor = 4'd1;
    req1_valid = 1'b1; req1_dividend = 4'd6; req1_divisor = 4'd2;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (out_quotient !== 4'd0 || out_remainder !== 4'd0) begin errors++; $display("FAIL reset_q_r: got %0d/%0d want 0/0", out_quotient, out_remainder); end
    checks++; if (out_id !== 1'b0 || out_div0 !== 1'b0) begin errors++; $display("FAIL reset_id_div0: got %0b/%0b want 0/0", out_id, out_div0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_readys: got %0b%0b want 00", req0_ready, req1_ready); end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%0b readys=%0b%0b want 0 00", busy, req0_ready, req1_ready); end
  endtask

  task automatic test_basic();
    int n;
    @(posedge clk); #1;
    out_ready = 1'b1;
    req0_valid = 1'b1; req0_dividend = 4'd13; req0_divisor = 4'd4;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL basic_ready: got %0b%0b want 10", req0_ready, req1_ready); end
    @(posedge clk); #1;
    req0_valid = 1'b0; req0_dividend = 4'd0; req0_divisor = 4'd0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %0b want 1", busy); end
    wait_out(n);
    checks++; if (n != W + 1) begin errors++; $display("FAIL basic_latency: got %0d want %0d", n, W + 1); end
    checks++; if (out_quotient !== 4'd3 || out_remainder !== 4'd1) begin errors++; $display("FAIL basic_result: got Q=%0d R=%0d want 3 1", out_quotient, out_remainder); end
    checks++; if (out_id !== 1'b0 || out_div0 !== 1'b0) begin errors++; $display("FAIL basic_tag: got id=%0b div0=%0b want 0 0", out_id, out_div0); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_release: valid=%0b busy=%0b want 0 0", out_valid, busy); end
  endtask

  task automatic test_div0();
    int n;
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_dividend = 4'd15; req1_divisor = 4'd0;
    @(negedge clk);
    checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL div0_ready: got %0b%0b want 01", req0_ready, req1_ready); end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    wait_out(n);
    checks++; if (n != 1) begin errors++; $display("FAIL div0_latency: got %0d want 1", n); end
    checks++; if (out_quotient !== 4'd15 || out_remainder !== 4'd15) begin errors++; $display("FAIL div0_result: got Q=%0d R=%0d want 15 15", out_quotient, out_remainder); end
    checks++; if (out_id !== 1'b1 || out_div0 !== 1'b1) begin errors++; $display("FAIL div0_tag: got id=%0b div0=%0b want 1 1", out_id, out_div0); end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int grants[$];
    logic [9:0] results[$];
    int guard;
    int n;
    @(posedge clk); #1;
    out_ready = 1'b1;
    req0_valid = 1'b1; req0_dividend = 4'd9; req0_divisor = 4'd2;
    req1_valid = 1'b1; req1_dividend = 4'd7; req1_divisor = 4'd3;
    @(negedge clk);
    guard = 0;
    while (grants.size() < 3 && guard < 60) begin
      if (req0_ready && req1_ready) begin
        checks++; errors++; $display("FAIL b2b_both_ready: got 11 want at most one");
      end
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (out_valid) results.push_back({out_quotient, out_remainder, out_id, out_div0});
      if (grants.size() < 3) begin
        @(posedge clk);
        @(negedge clk);
        guard++;
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    wait_out(n);
    checks++; if (grants.size() != 3) begin errors++; $display("FAIL b2b_grant_count: got %0d want 3", grants.size()); end
    else begin
      checks++; if (grants[0] != 0 || grants[1] != 1 || grants[2] != 0) begin errors++; $display("FAIL b2b_order: got %0d%0d%0d want 010", grants[0], grants[1], grants[2]); end
    end
    checks++; if (results.size() != 2) begin errors++; $display("FAIL b2b_result_count: got %0d want 2", results.size()); end
    else begin
      checks++; if (results[0] !== {4'd4, 4'd1, 1'b0, 1'b0}) begin errors++; $display("FAIL b2b_first: got %h want %h", results[0], {4'd4, 4'd1, 1'b0, 1'b0}); end
      checks++; if (results[1] !== {4'd2, 4'd1, 1'b1, 1'b0}) begin errors++; $display("FAIL b2b_second: got %h want %h", results[1], {4'd2, 4'd1, 1'b1, 1'b0}); end
    end
    checks++; if (out_valid !== 1'b1 || out_quotient !== 4'd4 || out_id !== 1'b0) begin errors++; $display("FAIL b2b_third: valid=%0b Q=%0d id=%0b want 1 4 0", out_valid, out_quotient, out_id); end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int n;
    int hs;
    @(posedge clk); #1;
    out_ready = 1'b0;
    req1_valid = 1'b1; req1_dividend = 4'd14; req1_divisor = 4'd5;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    // A second requester keeps asking while the result is stalled.
    req0_valid = 1'b1; req0_dividend = 4'd8; req0_divisor = 4'd1;
    @(negedge clk);
    wait_out(n);
    checks++; if (n != W + 1) begin errors++; $display("FAIL bp_latency: got %0d want %0d", n, W + 1); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_quotient !== 4'd2 || out_remainder !== 4'd4 ||
          out_id !== 1'b1 || out_div0 !== 1'b0 || busy !== 1'b1 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: v=%0b Q=%0d R=%0d id=%0b d0=%0b busy=%0b rdy=%0b%0b want 1 2 4 1 0 1 00",
                 i, out_valid, out_quotient, out_remainder, out_id, out_div0, busy, req0_ready, req1_ready);
      end
      @(posedge clk);
      @(negedge clk);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    out_ready = 1'b1;
    hs = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (out_valid && out_ready) hs++;
      @(posedge clk);
      @(negedge clk);
    end
    checks++; if (hs != 1) begin errors++; $display("FAIL bp_single_handshake: got %0d want 1", hs); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    int seen;
    @(posedge clk); #1;
    out_ready = 1'b1;
    req0_valid = 1'b1; req0_dividend = 4'd11; req0_divisor = 4'd3;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_quotient !== 4'd0 || out_remainder !== 4'd0 ||
        out_id !== 1'b0 || out_div0 !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset_outputs: v=%0b busy=%0b Q=%0d R=%0d id=%0b d0=%0b rdy=%0b%0b want all 0",
               out_valid, busy, out_quotient, out_remainder, out_id, out_div0, req0_ready, req1_ready);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      @(posedge clk);
      @(negedge clk);
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midrun_stale_result: got %0d valid cycles want 0", seen); end
    // Tie right after reset: requester 0 must win.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_dividend = 4'd6; req0_divisor = 4'd3;
    req1_valid = 1'b1; req1_dividend = 4'd1; req1_divisor = 4'd1;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL midrun_tie_after_reset: got %0b%0b want 10", req0_ready, req1_ready); end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    wait_out(n);
    checks++; if (out_valid !== 1'b1 || out_quotient !== 4'd2 || out_remainder !== 4'd0 || out_id !== 1'b0) begin
      errors++; $display("FAIL midrun_fresh_op: v=%0b Q=%0d R=%0d id=%0b want 1 2 0 0", out_valid, out_quotient, out_remainder, out_id);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_exhaustive();
    int done_ops;
    int guard;
    int rid;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ed0;
    done_ops = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        rid = int'($urandom_range(0, 1));
        if (b == 0) begin
          eq = 4'd15; er = 4'(a); ed0 = 1'b1;
        end else begin
          eq = 4'(a / b); er = 4'(a % b); ed0 = 1'b0;
        end
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(0, 1));
        if (rid == 0) begin
          req0_valid = 1'b1; req0_dividend = 4'(a); req0_divisor = 4'(b);
        end else begin
          req1_valid = 1'b1; req1_dividend = 4'(a); req1_divisor = 4'(b);
        end
        @(negedge clk);
        guard = 0;
        while (!((rid == 0) ? req0_ready : req1_ready) && guard < 20) begin
          @(posedge clk); #1;
          @(negedge clk);
          guard++;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_dividend = 4'($urandom_range(0, 15)); req1_divisor = 4'($urandom_range(0, 15));
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        guard = 0;
        while (!(out_valid && out_ready) && guard < 200) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          guard++;
        end
        checks++;
        if (!(out_valid && out_ready) || out_quotient !== eq || out_remainder !== er ||
            out_id !== 1'(rid) || out_div0 !== ed0) begin
          errors++;
          $display("FAIL exh %0d/%0d: got v=%0b Q=%0d R=%0d id=%0b d0=%0b want Q=%0d R=%0d id=%0d d0=%0b",
                   a, b, out_valid, out_quotient, out_remainder, out_id, out_div0, eq, er, rid, ed0);
        end else begin
          done_ops++;
        end
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (done_ops != 256 || out_valid !== 1'b0) begin errors++; $display("FAIL exh_count: got %0d results valid=%0b want 256 0", done_ops, out_valid); end
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_dividend = '0; req0_divisor = '0;
    req1_valid = 1'b0; req1_dividend = '0; req1_divisor = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_div0();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    test_exhaustive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
